uart_tx_arbiter: RTL and testbench

//  Shares one 8N1 UART transmitter among N_REQ byte sources with round-robin fairness.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM states, default widths and clocking constants.
// No logic; constants and types only.
// Imported by the arbiter top and its round-robin picker.
package uart_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DW_DEFAULT = 8;
  localparam int UART_BAUD  = 115200;
  localparam int CLK_HZ     = 50000000;
  localparam int GID_W      = 3;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first valid requester after ptr, scanning ptr+1, ptr+2, ... modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is taken.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] winner,
  output logic             any_valid
);

  logic [7:0]       valid_ext;
  logic [GID_W-1:0] idx;

  assign valid_ext = 8'(valid);

  // Scan from the farthest candidate down to the nearest so the nearest valid one wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GID_W'((int'(ptr) + k) % N_REQ);
      if (valid_ext[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one 8N1 UART transmitter among N_REQ byte sources (UART_ARB_BURST_EN adds locked bursts).
// Latency: tx_start rises 1 cycle after the accept edge; at least one IDLE cycle between bytes.
// Backpressure: req_ready only for the winner, only in IDLE with the transmitter idle; timeout drops the byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 1024
) (
  input  logic                CLOCK_50,
  input  logic                KEY,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
`ifdef UART_ARB_BURST_EN
  input  logic [N_REQ-1:0]    req_lock,
`endif
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic [GID_W-1:0]    grant_id,
  output logic                arb_busy,
  output logic                tx_err
);

  localparam int CW = $clog2(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] pick_w;
  logic [GID_W-1:0] sel_w;
  logic             any_valid;
  logic             hs;
  logic             timeout_hit;
  logic [CW-1:0]    to_cnt;
  logic [DW-1:0]    data_arr [8];

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .winner    (pick_w),
    .any_valid (any_valid)
  );

  // Unpack the flat data bus into per-requester bytes
  always_comb begin
    data_arr = '{default: '0};
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

`ifdef UART_ARB_BURST_EN
  logic [7:0] valid_ext;
  logic [7:0] lock_ext;
  logic       lock_hold;
  logic       forced;
  logic [3:0] burst_cnt;

  assign valid_ext = 8'(req_valid);
  assign lock_ext  = 8'(req_lock);
  assign forced    = lock_hold && valid_ext[grant_id];
  assign sel_w     = forced ? grant_id : pick_w;

  // Burst bookkeeping: keep the grant while locked, up to 16 contiguous bytes
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      lock_hold <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (hs) begin
      lock_hold <= 1'b0;
      burst_cnt <= forced ? burst_cnt + 4'd1 : 4'd0;
    end else if (state_q == WAIT_DONE && !tx_busy) begin
      lock_hold <= lock_ext[grant_id] && (burst_cnt != 4'hF);
    end
  end
`else
  assign sel_w = pick_w;
`endif

  // FSM state register
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state and handshake/start outputs
  always_comb begin
    state_d     = state_q;
    hs          = 1'b0;
    timeout_hit = 1'b0;
    req_ready   = '0;
    tx_start    = 1'b0;
    arb_busy    = 1'b1;
    case (state_q)
      IDLE: begin
        arb_busy = 1'b0;
        if (KEY && !tx_busy && any_valid) begin
          req_ready = N_REQ'(1) << sel_w;
          hs        = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (to_cnt == CW'(TIMEOUT - 2)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the accepted byte and advance the round-robin pointer
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= GID_W'(N_REQ - 1);
    end else if (hs) begin
      tx_data  <= data_arr[sel_w];
      grant_id <= sel_w;
      rr_ptr   <= sel_w;
    end
  end

  // Start-to-busy watchdog counter, saturating at TIMEOUT-1
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      to_cnt <= '0;
    end else if (state_q == LAUNCH) begin
      to_cnt <= '0;
    end else if (state_q == WAIT_BUSY && !tx_busy && to_cnt != CW'(TIMEOUT - 1)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky timeout flag
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY)             tx_err <= 1'b0;
    else if (timeout_hit) tx_err <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed steps plus randomized traffic against a queue-based model.
// Transmitter modelled as a busy pulse of configurable lag and length after each tx_start.
// Honours UART_ARB_BURST_EN for the locked-burst step.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 1024;

  logic            CLOCK_50  = 1'b0;
  logic            KEY       = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data  = '0;
`ifdef UART_ARB_BURST_EN
  logic [N-1:0]    req_lock  = '0;
`endif
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy   = 1'b0;
  logic [2:0]      grant_id;
  logic            arb_busy;
  logic            tx_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // transmitter model controls
  logic xmt_en   = 1'b1;
  int   busy_len = 8;
  int   lag_max  = 0;
  int   lag_c    = 0;
  int   len_c    = 0;
  logic pend     = 1'b0;

  // reference model: per-requester byte queues and round-robin pointer
  logic [7:0] mem [N][32];
  int         head [N];
  int         tail [N];
  int         mp;

  uart_tx_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY       (KEY),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef UART_ARB_BURST_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .tx_err    (tx_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // transmitter: after tx_start, optional lag, then busy for busy_len cycles
  always @(negedge CLOCK_50) begin
    if (!KEY || !xmt_en) begin
      tx_busy = 1'b0;
      pend    = 1'b0;
    end else if (tx_busy) begin
      if (len_c <= 1) tx_busy = 1'b0;
      else            len_c   = len_c - 1;
    end else if (pend) begin
      if (lag_c == 0) begin
        tx_busy = 1'b1;
        pend    = 1'b0;
      end else begin
        lag_c = lag_c - 1;
      end
    end else if (tx_start) begin
      pend  = 1'b1;
      lag_c = $urandom_range(lag_max, 0);
      len_c = busy_len;
    end
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = head[i] < tail[i];
      req_data[i*DW +: DW] = (head[i] < tail[i]) ? mem[i][head[i]] : 8'h00;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive_reqs();
  endtask

  task automatic push(input int r, input logic [7:0] d);
    if (tail[r] < 32) begin
      mem[r][tail[r]] = d;
      tail[r]++;
    end
  endtask

  function automatic int rr_next(input int p);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (head[idx] < tail[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    KEY = 1'b0;
    tick();
    tick();
    KEY = 1'b1;
    mp  = N - 1;
  endtask

  // wait for ready, expect it on ew, then check the launch cycle
  task automatic serve_one(input int ew, input logic [7:0] ed, input string tag);
    int n;
    n = 0;
    #2;
    while (req_ready == '0 && n < 400) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << ew);
    tick();
    check({tag, "_start"}, 32'(tx_start), 32'd1);
    check({tag, "_data"},  32'(tx_data),  32'(ed));
    check({tag, "_gid"},   32'(grant_id), 32'(ew));
  endtask

  // model-driven service of the next byte
  task automatic serve_model(input string tag);
    int w;
    w = rr_next(mp);
    serve_one(w, mem[w][head[w]], tag);
    mp = w;
    head[w]++;
    drive_reqs();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((arb_busy || tx_busy) && n < 400) begin
      tick();
      n++;
    end
    check(tag, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int w;
    int r;

    // 1: reset with every requester valid
    req_valid = '1;
    req_data  = 32'hDEADBEEF;
    #2 KEY = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start),  32'd0);
    check("rst_busy",  32'(arb_busy),  32'd0);
    check("rst_err",   32'(tx_err),    32'd0);
    check("rst_gid",   32'(grant_id),  32'd0);
    check("rst_data",  32'(tx_data),   32'd0);
    clear_q();
    KEY = 1'b1;
    mp  = N - 1;
    tick();

    // 2: single source
    busy_len = 20;
    push(2, 8'hA5);
    drive_reqs();
    serve_one(2, 8'hA5, "single");
    mp = 2;
    head[2]++;
    drive_reqs();
    tick();
    check("single_pulse", 32'(tx_start), 32'd0);
    repeat (8) tick();
    check("single_midbusy", 32'(arb_busy), 32'd1);
    check("single_hold",    32'(tx_data),  32'hA5);
    wait_idle("single_idle");

    // 3: fairness, all four continuously valid
    do_reset();
    clear_q();
    busy_len = 6;
    for (int i = 0; i < N; i++) begin
      push(i, 8'($urandom));
      push(i, 8'($urandom));
    end
    drive_reqs();
    for (int j = 0; j < 8; j++) begin
      w = order[j];
      serve_one(w, mem[w][head[w]], "fair");
      mp = w;
      head[w]++;
      drive_reqs();
    end
    wait_idle("fair_idle");

    // 4: timeout with transmitter never going busy
    xmt_en = 1'b0;
    push(1, 8'h3C);
    drive_reqs();
    serve_model("to_launch");
    for (int i = 1; i <= TO; i++) begin
      tick();
      if (i == TO - 1) begin
        check("to_err_early", 32'(tx_err),   32'd0);
        check("to_busy_wait", 32'(arb_busy), 32'd1);
      end
    end
    check("to_err_set",  32'(tx_err),   32'd1);
    check("to_idle",     32'(arb_busy), 32'd0);
    xmt_en = 1'b1;
    push(0, 8'h11);
    push(3, 8'h33);
    drive_reqs();
    serve_model("to_next_a");
    serve_model("to_next_b");
    wait_idle("to_after_idle");
    check("to_err_sticky", 32'(tx_err), 32'd1);

    // 5: reset in the middle of a frame
    do_reset();
    check("rst2_err", 32'(tx_err), 32'd0);
    clear_q();
    busy_len = 20;
    push(2, 8'h5A);
    drive_reqs();
    serve_model("mid");
    repeat (4) tick();
    check("mid_in_frame", 32'(arb_busy), 32'd1);
    for (int i = 0; i < N; i++) push(i, 8'(8'h80 + i));
    drive_reqs();
    KEY = 1'b0;
    #1;
    check("mid_rst_idle",  32'(arb_busy),  32'd0);
    check("mid_rst_start", 32'(tx_start),  32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    KEY = 1'b1;
    mp  = N - 1;
    serve_one(0, mem[0][head[0]], "mid_first");
    mp = 0;
    head[0]++;
    clear_q();
    wait_idle("mid_idle");

`ifdef UART_ARB_BURST_EN
    // 6: locked burst capped at 16 bytes
    do_reset();
    clear_q();
    busy_len = 3;
    for (int i = 0; i < 20; i++) push(1, 8'($urandom));
    push(3, 8'hC3);
    req_lock = 4'b0010;
    drive_reqs();
    for (int j = 0; j < 16; j++) begin
      serve_one(1, mem[1][head[1]], "burst");
      head[1]++;
      drive_reqs();
    end
    serve_one(3, 8'hC3, "burst_cap");
    head[3]++;
    req_lock = '0;
    clear_q();
    wait_idle("burst_idle");
`endif

    // random traffic against the model, with mid-frame arrivals and withdrawals
    do_reset();
    clear_q();
    lag_max = 3;
    for (int round = 0; round < 6; round++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(4, 0);
        for (int b = 0; b < r; b++) push(i, 8'($urandom));
      end
      drive_reqs();
      for (int guard = 0; guard < 100 && any_pending(); guard++) begin
        busy_len = $urandom_range(12, 2);
        serve_model("rand");
        if ($urandom_range(3, 0) == 0) begin
          push($urandom_range(N - 1, 0), 8'($urandom));
        end
        if ($urandom_range(5, 0) == 0) begin
          r = $urandom_range(N - 1, 0);
          if (head[r] < tail[r]) head[r]++;
        end
        drive_reqs();
      end
      wait_idle("rand_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
